// File: rtl/seq_divider_4bit.sv
// seq_divider_4bit: 4-bit unsigned restoring divider, one quotient bit per cycle,
// using a borrow-ripple subtractor's borrow-out as the restore decision.  Rev 1.0
`default_nettype none

module Subtractor_4bits (
   input  logic [3:0] A,
   input  logic [3:0] B,
   output logic [3:0] Diff,
   output logic       Cout
);
   logic [4:0] borrow;

   assign borrow[0] = 1'b0;

   for (genvar i = 0; i < 4; i++) begin : g_bit
      assign Diff[i]       = A[i] ^ B[i] ^ borrow[i];
      assign borrow[i+1]   = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & borrow[i]);
   end

   assign Cout = borrow[4];
endmodule

module seq_divider_4bit (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] dividend,
   input  logic [3:0] divisor,
   output logic       busy,
   output logic       done,
   output logic [3:0] quotient,
   output logic [3:0] remainder,
   output logic       div_by_zero
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] r_q, r_d;
   logic [3:0] q_q, q_d;
   logic [3:0] d_q, d_d;
   logic [1:0] cnt_q, cnt_d;
   logic [3:0] quot_q, quot_d;
   logic [3:0] rem_q, rem_d;
   logic       dbz_q, dbz_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;

   logic [3:0] trial;
   logic [3:0] diff;
   logic       borrow_out;

   // R[3] is always 0 before the shift, so dropping it loses nothing.
   assign trial = {r_q[2:0], q_q[3]};

   Subtractor_4bits u_sub (
      .A    (trial),
      .B    (d_q),
      .Diff (diff),
      .Cout (borrow_out)
   );

   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      q_d     = q_q;
      d_d     = d_q;
      cnt_d   = cnt_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;

      case (state_q)
         // The DONE cycle's exit edge doubles as an accept edge so a held
         // start sustains one division every five cycles.
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (start) begin
               if (divisor == 4'd0) begin
                  quot_d  = 4'hF;
                  rem_d   = dividend;
                  dbz_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  q_d     = dividend;
                  d_d     = divisor;
                  r_d     = 4'd0;
                  cnt_d   = 2'd0;
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            if (!borrow_out) begin
               r_d = diff;
               q_d = {q_q[2:0], 1'b1};
            end else begin
               r_d = trial;
               q_d = {q_q[2:0], 1'b0};
            end
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
               quot_d  = q_d;
               rem_d   = r_d;
               dbz_d   = 1'b0;
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         r_q     <= 4'd0;
         q_q     <= 4'd0;
         d_q     <= 4'd0;
         cnt_q   <= 2'd0;
         quot_q  <= 4'd0;
         rem_q   <= 4'd0;
         dbz_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         q_q     <= q_d;
         d_q     <= d_d;
         cnt_q   <= cnt_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;
endmodule

`default_nettype wire

// File: tb/tb_seq_divider_4bit.sv
// tb_seq_divider_4bit: table-driven directed checks plus hand sequences for
// busy-start, back-to-back and mid-run reset.  Rev 1.0
`default_nettype none

module tb_seq_divider_4bit;
   logic       clk;
   logic       rst;
   logic       start;
   logic [3:0] dividend;
   logic [3:0] divisor;
   logic       busy;
   logic       done;
   logic [3:0] quotient;
   logic [3:0] remainder;
   logic       div_by_zero;

   int n_cmp = 0;
   int n_err = 0;

   seq_divider_4bit dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] dvd;
      logic [3:0] dvs;
      logic [3:0] exp_q;
      logic [3:0] exp_r;
      logic       exp_dbz;
      int         exp_lat;
   } vec_t;

   vec_t vecs[10];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Latency counts post-edge samples from E0: done seen after E4 gives 5.
   task automatic run_vec(input vec_t v, input string tag);
      int lat;
      dividend = v.dvd;
      divisor  = v.dvs;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      dividend = ~v.dvd;
      divisor  = v.dvs + 4'd3;
      check({tag, " busy_after_E0"}, int'(busy), 1);
      lat = 1;
      while (done !== 1'b1 && lat < 8) begin
         tick();
         lat++;
      end
      check({tag, " done_latency"}, lat, v.exp_lat);
      check({tag, " quotient"}, int'(quotient), int'(v.exp_q));
      check({tag, " remainder"}, int'(remainder), int'(v.exp_r));
      check({tag, " div_by_zero"}, int'(div_by_zero), int'(v.exp_dbz));
      tick();
      check({tag, " done_one_cycle"}, int'(done), 0);
      check({tag, " idle_after"}, int'(busy), 0);
      check({tag, " result_hold"}, int'(quotient), int'(v.exp_q));
   endtask

   initial begin
      int done_seen;

      vecs[0] = '{4'd13, 4'd3,  4'd4,  4'd1, 1'b0, 5};
      vecs[1] = '{4'd7,  4'd9,  4'd0,  4'd7, 1'b0, 5};
      vecs[2] = '{4'd0,  4'd5,  4'd0,  4'd0, 1'b0, 5};
      vecs[3] = '{4'd15, 4'd1,  4'd15, 4'd0, 1'b0, 5};
      vecs[4] = '{4'd15, 4'd15, 4'd1,  4'd0, 1'b0, 5};
      vecs[5] = '{4'd9,  4'd0,  4'hF,  4'd9, 1'b1, 1};
      vecs[6] = '{4'd14, 4'd4,  4'd3,  4'd2, 1'b0, 5};
      vecs[7] = '{4'd8,  4'd7,  4'd1,  4'd1, 1'b0, 5};
      vecs[8] = '{4'd15, 4'd2,  4'd7,  4'd1, 1'b0, 5};
      vecs[9] = '{4'd0,  4'd0,  4'hF,  4'd0, 1'b1, 1};

      rst      = 1'b1;
      start    = 1'b0;
      dividend = 4'd0;
      divisor  = 4'd0;
      tick();
      tick();
      check("reset busy", int'(busy), 0);
      check("reset done", int'(done), 0);
      check("reset quotient", int'(quotient), 0);
      check("reset remainder", int'(remainder), 0);
      check("reset dbz", int'(div_by_zero), 0);

      // rst beats start on the same edge
      start    = 1'b1;
      dividend = 4'd5;
      divisor  = 4'd1;
      tick();
      check("rst_priority busy", int'(busy), 0);
      start = 1'b0;
      rst   = 1'b0;
      tick();

      for (int i = 0; i < 10; i++) begin
         run_vec(vecs[i], $sformatf("vec%0d", i));
         tick();
      end

      // start while busy is ignored; held start into E5 is accepted
      dividend = 4'd12; divisor = 4'd5; start = 1'b1;
      tick();                                   // E0
      start = 1'b0;
      tick();                                   // E1
      dividend = 4'd6; divisor = 4'd2; start = 1'b1;
      tick();                                   // E2 (ignored)
      check("b2b busy_at_E2", int'(busy), 1);
      start = 1'b0;
      tick();                                   // E3
      tick();                                   // E4
      check("b2b first done", int'(done), 1);
      check("b2b first quotient", int'(quotient), 2);
      check("b2b first remainder", int'(remainder), 2);
      dividend = 4'd6; divisor = 4'd2; start = 1'b1;
      tick();                                   // E5 (accepted)
      start = 1'b0;
      check("b2b E5 done_low", int'(done), 0);
      check("b2b E5 busy", int'(busy), 1);
      check("b2b hold quotient", int'(quotient), 2);
      tick(); tick(); tick();                   // E6..E8
      check("b2b no_early_done", int'(done), 0);
      tick();                                   // E9
      check("b2b second done", int'(done), 1);
      check("b2b second quotient", int'(quotient), 3);
      check("b2b second remainder", int'(remainder), 0);
      tick();
      tick();

      // reset in the middle of a run aborts it
      run_vec(vecs[0], "pre_reset");
      dividend = 4'd10; divisor = 4'd3; start = 1'b1;
      tick();                                   // E0
      start = 1'b0;
      tick();                                   // E1
      rst = 1'b1;
      tick();                                   // E2 with reset
      rst = 1'b0;
      check("abort busy", int'(busy), 0);
      check("abort done", int'(done), 0);
      check("abort quotient", int'(quotient), 0);
      check("abort remainder", int'(remainder), 0);
      check("abort dbz", int'(div_by_zero), 0);
      done_seen = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (done === 1'b1) done_seen = 1;
      end
      check("abort no_done_pulse", done_seen, 0);
      run_vec('{4'd10, 4'd3, 4'd3, 4'd1, 1'b0, 5}, "post_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

`default_nettype wire
